// File: rtl/corelet_ctrl_if.sv
// Host/corelet-facing bundle for corelet_ctrl. master = sequencer, slave = host + corelet.
// The perf counter signals exist only when CORELET_CTRL_PERF_EN is defined.
interface corelet_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [7:0]        num_vec;
  logic              busy;
  logic              done;
  logic              xw_cen;
  logic [ADDR_W-1:0] xw_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic              l0_full;
  logic              load;
  logic              execute;
  logic              ofifo_valid;
  logic              ofifo_rd;
  logic              psum_wen;
  logic              psum_cen;
  logic [ADDR_W-1:0] psum_addr;

`ifdef CORELET_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_stall;

  modport master (
    input  start, num_vec, l0_full, ofifo_valid,
    output busy, done, xw_cen, xw_addr, l0_wr, l0_rd, load, execute,
           ofifo_rd, psum_wen, psum_cen, psum_addr, perf_cycles, perf_stall
  );

  modport slave (
    output start, num_vec, l0_full, ofifo_valid,
    input  busy, done, xw_cen, xw_addr, l0_wr, l0_rd, load, execute,
           ofifo_rd, psum_wen, psum_cen, psum_addr, perf_cycles, perf_stall
  );
`else
  modport master (
    input  start, num_vec, l0_full, ofifo_valid,
    output busy, done, xw_cen, xw_addr, l0_wr, l0_rd, load, execute,
           ofifo_rd, psum_wen, psum_cen, psum_addr
  );

  modport slave (
    output start, num_vec, l0_full, ofifo_valid,
    input  busy, done, xw_cen, xw_addr, l0_wr, l0_rd, load, execute,
           ofifo_rd, psum_wen, psum_cen, psum_addr
  );
`endif
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences one corelet pass (kernel load, activation stream,
// execute, output drain). Optional perf counters behind CORELET_CTRL_PERF_EN.
//
// state    | meaning
// IDLE     | waiting for start with num_vec != 0
// KWR      | read kernel rows from xw SRAM into L0 (stalls on l0_full)
// KLD      | l0_rd + load for row cycles (kernel capture)
// GAP      | GAP idle cycles for weight propagation
// AWR      | read activation vectors into L0 (stalls on l0_full)
// EXE      | l0_rd + execute for num_vec cycles
// DRN      | pop OFIFO into psum SRAM whenever ofifo_valid
// DONE     | one-cycle done pulse, back to IDLE
module corelet_ctrl #(
  parameter int row         = 8,
  parameter int col         = 8,
  parameter int ADDR_W      = 11,
  parameter int KERNEL_BASE = 0,
  parameter int ACT_BASE    = 64,
  parameter int GAP         = 16
) (
  input logic             clk,
  input logic             reset,
  corelet_ctrl_if.master  bus
);

  localparam int RW = $clog2(row + 1);
  localparam int GW = $clog2(GAP + 1);

  if (row < 1 || col < 1 || GAP < 1) begin : g_cfg_err
    $error("corelet_ctrl: row, col and GAP must all be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_KWR, ST_KLD, ST_GAP, ST_AWR, ST_EXE, ST_DRN, ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [RW-1:0]     rcnt, rcnt_n;
  logic [7:0]        vcnt, vcnt_n;
  logic [7:0]        nv, nv_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [ADDR_W-1:0] paddr, paddr_n;
  logic [ADDR_W-1:0] xaddr;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              stall;
  logic              l0_wr_q, l0_rd_q, load_q, exe_q, busy_q, done_q;

  assign accept = (state == ST_IDLE) && bus.start && (bus.num_vec != 8'd0);

  // Next-state, counter updates, SRAM read issue and OFIFO pop decisions.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    vcnt_n  = vcnt;
    nv_n    = nv;
    gcnt_n  = gcnt;
    paddr_n = paddr;
    xaddr   = '0;
    issue   = 1'b0;
    pop     = 1'b0;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_KWR;
          nv_n    = bus.num_vec;
          rcnt_n  = '0;
          vcnt_n  = '0;
          gcnt_n  = '0;
          paddr_n = '0;
        end
      end
      ST_KWR: begin
        // Address follows the issue count, so it holds while l0_full stalls.
        xaddr = ADDR_W'(KERNEL_BASE) + ADDR_W'(rcnt);
        if (rcnt == RW'(row)) begin
          // Last read was issued last cycle; its l0_wr is on the bus now.
          state_n = ST_KLD;
          rcnt_n  = '0;
        end else if (bus.l0_full) begin
          stall = 1'b1;
        end else begin
          issue  = 1'b1;
          rcnt_n = rcnt + RW'(1);
        end
      end
      ST_KLD: begin
        if (rcnt == RW'(row - 1)) begin
          state_n = ST_GAP;
          rcnt_n  = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt == GW'(GAP - 1)) begin
          state_n = ST_AWR;
          gcnt_n  = '0;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      ST_AWR: begin
        xaddr = ADDR_W'(ACT_BASE) + ADDR_W'(vcnt);
        if (vcnt == nv) begin
          state_n = ST_EXE;
          vcnt_n  = '0;
        end else if (bus.l0_full) begin
          stall = 1'b1;
        end else begin
          issue  = 1'b1;
          vcnt_n = vcnt + 8'd1;
        end
      end
      ST_EXE: begin
        if (vcnt == nv - 8'd1) begin
          state_n = ST_DRN;
          vcnt_n  = '0;
        end else begin
          vcnt_n = vcnt + 8'd1;
        end
      end
      ST_DRN: begin
        if (bus.ofifo_valid) begin
          pop     = 1'b1;
          paddr_n = paddr + ADDR_W'(1);
          if (vcnt == nv - 8'd1) begin
            state_n = ST_DONE;
            vcnt_n  = '0;
          end else begin
            vcnt_n = vcnt + 8'd1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered corelet strobes (decoded from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      rcnt    <= '0;
      vcnt    <= '0;
      nv      <= '0;
      gcnt    <= '0;
      paddr   <= '0;
      l0_wr_q <= 1'b0;
      l0_rd_q <= 1'b0;
      load_q  <= 1'b0;
      exe_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      rcnt    <= rcnt_n;
      vcnt    <= vcnt_n;
      nv      <= nv_n;
      gcnt    <= gcnt_n;
      paddr   <= paddr_n;
      l0_wr_q <= issue;
      l0_rd_q <= (state_n == ST_KLD) || (state_n == ST_EXE);
      load_q  <= (state_n == ST_KLD);
      exe_q   <= (state_n == ST_EXE);
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= (state_n == ST_DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.xw_cen    = ~issue;
  assign bus.xw_addr   = xaddr;
  assign bus.l0_wr     = l0_wr_q;
  assign bus.l0_rd     = l0_rd_q;
  assign bus.load      = load_q;
  assign bus.execute   = exe_q;
  assign bus.ofifo_rd  = pop;
  assign bus.psum_cen  = ~pop;
  assign bus.psum_wen  = ~pop;
  assign bus.psum_addr = paddr;

`ifdef CORELET_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  // Saturating busy/stall counters, cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall && (perf_stall_q != 32'hFFFF_FFFF))   perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: table of whole passes plus hand-written
// reset / illegal-start sequences. Expected SRAM and psum addresses are queued
// when a pass is launched and popped as the DUT issues them.
module tb_corelet_ctrl;

  localparam int AW = 11;
  localparam int KB = 0;
  localparam int AB = 64;

  logic clk;
  logic reset;

  corelet_ctrl_if #(.ADDR_W(AW)) bus ();

  corelet_ctrl #(
    .row(8), .col(8), .ADDR_W(AW), .KERNEL_BASE(KB), .ACT_BASE(AB), .GAP(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nv;
    int          fs;        // first cycle (rel. to start) with l0_full=1
    int          fl;        // number of l0_full cycles
    logic [15:0] vpat;      // ofifo_valid bits from drain entry, LSB first
    int          vlen;
    int          sp_rel;    // cycle of a spurious start, -1 = none
    int          sp_nv;
    int          exp_done;  // cycle of done pulse, start cycle = 0
    int          exp_stall;
  } pass_t;

  pass_t tbl[6];
  int    n_chk;
  int    n_fail;
  int    xw_q[$];
  int    ps_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_l0_wr"},     bus.l0_wr, 0);
    chk({tag, "_l0_rd"},     bus.l0_rd, 0);
    chk({tag, "_load"},      bus.load, 0);
    chk({tag, "_execute"},   bus.execute, 0);
    chk({tag, "_ofifo_rd"},  bus.ofifo_rd, 0);
    chk({tag, "_xw_cen"},    bus.xw_cen, 1);
    chk({tag, "_psum_cen"},  bus.psum_cen, 1);
    chk({tag, "_psum_wen"},  bus.psum_wen, 1);
  endtask

  task automatic run_pass(input pass_t p);
    int d0, done_rel, n_wr, n_load, n_exe, n_rd, n_done, n_busy;
    xw_q.delete();
    ps_q.delete();
    for (int i = 0; i < 8; i++) xw_q.push_back(KB + i);
    for (int j = 0; j < p.nv; j++) begin
      xw_q.push_back(AB + j);
      ps_q.push_back(j);
    end
    d0 = 34 + 2 * p.nv + 1 + p.fl;
    done_rel = -1;
    n_wr = 0; n_load = 0; n_exe = 0; n_rd = 0; n_done = 0; n_busy = 0;
    bus.start       = 1'b1;
    bus.num_vec     = 8'(p.nv);
    bus.l0_full     = 1'b0;
    bus.ofifo_valid = 1'b1;
    for (int rel = 1; rel <= p.exp_done + 20 && done_rel < 0; rel++) begin
      tick();
      bus.start   = (rel == p.sp_rel);
      bus.num_vec = (rel == p.sp_rel) ? 8'(p.sp_nv) : 8'hAA;
      bus.l0_full = (rel >= p.fs) && (rel < p.fs + p.fl);
      if (rel < d0 || rel - d0 >= p.vlen) bus.ofifo_valid = 1'b1;
      else                                bus.ofifo_valid = p.vpat[rel - d0];
      #2;
      chk("load_and_execute", bus.load & bus.execute, 0);
      chk("l0_wr_and_l0_rd", bus.l0_wr & bus.l0_rd, 0);
      if (!bus.xw_cen) begin
        chk("xw_read_expected", xw_q.size() > 0, 1);
        if (xw_q.size() > 0) chk("xw_addr", bus.xw_addr, xw_q.pop_front());
      end else if (bus.l0_full && xw_q.size() > 0) begin
        chk("xw_addr_frozen", bus.xw_addr, xw_q[0]);
      end
      if (!bus.psum_cen) begin
        chk("psum_wen", bus.psum_wen, 0);
        chk("psum_with_ofifo_rd", bus.ofifo_rd, 1);
        chk("psum_write_expected", ps_q.size() > 0, 1);
        if (ps_q.size() > 0) chk("psum_addr", bus.psum_addr, ps_q.pop_front());
      end
      if (rel >= d0 && rel < p.exp_done) chk("ofifo_rd_follows_valid", bus.ofifo_rd, bus.ofifo_valid);
      n_wr   += int'(bus.l0_wr);
      n_load += int'(bus.load);
      n_exe  += int'(bus.execute);
      n_rd   += int'(bus.ofifo_rd);
      n_busy += int'(bus.busy);
      if (bus.done) begin
        n_done++;
        done_rel = rel;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", done_rel >= 0, 1);
    chk("done_cycle", done_rel, p.exp_done);
    chk("l0_wr_count", n_wr, 8 + p.nv);
    chk("load_count", n_load, 8);
    chk("execute_count", n_exe, p.nv);
    chk("ofifo_rd_count", n_rd, p.nv);
    chk("busy_cycles", n_busy, p.exp_done);
    chk("xw_reads_left", xw_q.size(), 0);
    chk("psum_writes_left", ps_q.size(), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      #2;
      chk("busy_after_done", bus.busy, 0);
      n_done += int'(bus.done);
    end
    chk("done_pulses", n_done, 1);
`ifdef CORELET_CTRL_PERF_EN
    chk("perf_cycles", bus.perf_cycles, n_busy);
    chk("perf_stall", bus.perf_stall, p.exp_stall);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    tbl[0] = '{nv:4, fs:0,  fl:0, vpat:16'h0,  vlen:0, sp_rel:-1, sp_nv:0, exp_done:47, exp_stall:0};
    tbl[1] = '{nv:4, fs:35, fl:3, vpat:16'h0,  vlen:0, sp_rel:-1, sp_nv:0, exp_done:50, exp_stall:3};
    tbl[2] = '{nv:3, fs:0,  fl:0, vpat:16'h29, vlen:6, sp_rel:-1, sp_nv:0, exp_done:47, exp_stall:3};
    tbl[3] = '{nv:2, fs:0,  fl:0, vpat:16'h0,  vlen:0, sp_rel:37, sp_nv:5, exp_done:41, exp_stall:0};
    tbl[4] = '{nv:1, fs:3,  fl:2, vpat:16'h0,  vlen:0, sp_rel:40, sp_nv:7, exp_done:40, exp_stall:2};
    tbl[5] = '{nv:5, fs:5,  fl:1, vpat:16'h76, vlen:7, sp_rel:-1, sp_nv:0, exp_done:53, exp_stall:3};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_vec = 8'd0;
    bus.l0_full = 1'b0;
    bus.ofifo_valid = 1'b0;
    repeat (3) tick();
    #2;
    chk_idle_outputs("reset");
    chk("reset_xw_addr", bus.xw_addr, 0);
    chk("reset_psum_addr", bus.psum_addr, 0);
`ifdef CORELET_CTRL_PERF_EN
    chk("reset_perf_cycles", bus.perf_cycles, 0);
    chk("reset_perf_stall", bus.perf_stall, 0);
`endif
    reset = 1'b0;
    tick();

    // start with num_vec == 0 must be ignored
    bus.start = 1'b1;
    bus.num_vec = 8'd0;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("zero_nv_busy", bus.busy, 0);
      chk("zero_nv_xw_cen", bus.xw_cen, 1);
      tick();
    end

    // reset in the middle of EXE aborts within one cycle
    bus.start = 1'b1;
    bus.num_vec = 8'd4;
    bus.ofifo_valid = 1'b1;
    for (int rel = 1; rel <= 40; rel++) begin
      tick();
      bus.start = 1'b0;
    end
    #2;
    chk("pre_reset_execute", bus.execute, 1);
    chk("pre_reset_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    #2;
    chk_idle_outputs("abort");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #2;
      chk("abort_no_done", bus.done, 0);
      chk("abort_idle_busy", bus.busy, 0);
    end

    for (int t = 0; t < 6; t++) run_pass(tbl[t]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Sequencer for one corelet pass: kernel load, activation stream, execute, output drain. It drives the corelet strobes (l0_wr, l0_rd, load, execute, ofifo_rd) and the activation/kernel SRAM and psum SRAM ports, and it sits between the top-level testbench/host and the corelet. The corelet registers l0_wr/l0_rd/load/execute internally, so every strobe here is a registered output.

Parameters:
row, 8, systolic array rows (kernel vectors loaded per pass)
col, 8, systolic array columns
ADDR_W, 11, SRAM address width
KERNEL_BASE, 0, activation/kernel SRAM address of kernel row 0
ACT_BASE, 64, activation/kernel SRAM address of activation vector 0
GAP, 16, idle cycles after kernel load before activations are written (weight propagation)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begin pass
num_vec  in  8  activation vectors this pass; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at pass end
xw_cen  out  1  activation/kernel SRAM chip enable, active-low; 1-cycle read latency
xw_addr  out  ADDR_W  activation/kernel SRAM address
l0_wr  out  1  L0 write strobe
l0_rd  out  1  L0 read strobe
l0_full  in  1  L0 full
load  out  1  corelet load (kernel capture)
execute  out  1  corelet execute
ofifo_valid  in  1  OFIFO holds a complete row
ofifo_rd  out  1  OFIFO pop
psum_wen  out  1  psum SRAM write enable, active-low
psum_cen  out  1  psum SRAM chip enable, active-low
psum_addr  out  ADDR_W  psum SRAM address, 0-based per pass

Behaviour:
- Reset: state IDLE. busy=0, done=0, l0_wr=0, l0_rd=0, load=0, execute=0, ofifo_rd=0, xw_cen=1, psum_cen=1, psum_wen=1, all addresses 0, all counters 0. Reset mid-pass aborts in one cycle; no partial done.
- IDLE: accepts start only when num_vec!=0. It latches num_vec and goes to KWR. start with num_vec==0, or any start while busy, is ignored.
- KWR (kernel write): issues a read per cycle at xw_addr=KERNEL_BASE+i, i=0..row-1, with xw_cen=0. l0_wr is asserted the cycle after each issued read, matching the SRAM latency.
  - If l0_full=1, no new read is issued and the address holds. A pending l0_wr still completes.
  - Exits to KLD when row writes are done.
- KLD: l0_rd=1 and load=1 for row consecutive cycles, then load=0. Then GAP cycles with all strobes low. Then go to AWR.
- AWR: same as KWR but reads ACT_BASE+j, j=0..num_vec-1, with the same stall rule. Then go to EXE.
- EXE: l0_rd=1 and execute=1 for num_vec cycles, then go to DRN.
- DRN: in any cycle with ofifo_valid=1, assert ofifo_rd=1 and psum_cen=0, psum_wen=0 in the same cycle; psum_addr increments after each write. Exit when num_vec rows are popped.
  - ofifo_valid=0 is a stall with no timeout.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE. start arriving in the DONE cycle is ignored.
- load and execute are never high together. l0_wr and l0_rd are never high together.
- Counters: row counter is ceil(log2(row+1)) bits; vector counter is 8 bits; GAP counter is ceil(log2(GAP+1)) bits. No wrap occurs for legal num_vec (1..255).

Optional Feature:
CORELET_CTRL_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_stall[31:0].
  - Both clear on accepted start.
  - perf_cycles counts busy cycles.
  - perf_stall counts cycles stalled by l0_full in KWR/AWR or by ofifo_valid=0 in DRN.
  - Both saturate at 2^32-1 and hold after done until the next start; reset clears them.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Nominal pass, num_vec=4, l0_full=0, ofifo_valid=1 always:
  - xw_addr 0..7, then 64..67; load high exactly 8 cycles; execute high exactly 4 cycles.
  - psum writes at addr 0..3; done pulses once.
  - With defaults, done lands 1+(8+1)+8+16+(4+1)+4+4 cycles after start.
- Stall: hold l0_full=1 for 3 cycles during AWR -> xw_addr frozen and no extra l0_wr; total l0_wr count is still 8+num_vec; pass is 3 cycles longer.
- Drain gaps: num_vec=3, ofifo_valid toggling 1,0,0,1,0,1 -> ofifo_rd exactly on the 3 valid cycles; psum_addr 0,1,2.
- Illegal starts: start with num_vec=0 -> busy stays 0. start during EXE -> ignored, and latched num_vec is unchanged.
- Reset during EXE -> next cycle all strobes 0, xw_cen=psum_cen=1, IDLE. A fresh start then runs a full pass.
- With CORELET_CTRL_PERF_EN and the stall scenario -> perf_stall=3, and perf_cycles equals the busy-high cycle count.
